// File: rtl/pipe_if_pkg.sv
// Shared CPU definitions: PC-source encodings, NOP word, IF state encoding,
// plus the small selection/extension helpers used by next-PC logic.
package cpu_defs;

    localparam logic [1:0]  PCSRC_SEQ = 2'b00;
    localparam logic [1:0]  PCSRC_BR  = 2'b01;
    localparam logic [1:0]  PCSRC_JR  = 2'b10;
    localparam logic [1:0]  PCSRC_J   = 2'b11;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

    typedef enum logic {
        IF_FETCH = 1'b0,
        IF_HOLD  = 1'b1
    } if_state_e;

    // Two-way 32-bit select: sel=0 picks a, sel=1 picks b.
    function automatic logic [31:0] mux2x32(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic        sel);
        return sel ? b : a;
    endfunction

    // Sign-extend an 18-bit byte offset (imm<<2) to 32 bits.
    function automatic logic [31:0] sext18(input logic [17:0] v);
        return {{14{v[17]}}, v};
    endfunction

endpackage

// File: rtl/pipe_if_npc.sv
// Next-PC target selection for redirects decoded in ID.
// Branch target is relative to the PC+4 of the redirecting instruction,
// j keeps the upper nibble of that PC+4, jr forces word alignment.
module pipe_if_npc
    import cpu_defs::*;
(
    input  logic [1:0]  pcsource,
    input  logic [31:0] pc4,
    input  logic [17:0] imm18,
    input  logic [27:0] index28,
    input  logic [31:0] rd1,
    output logic [31:0] target
);

    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_jr_target;
    logic [31:0] w_lo_sel;
    logic [31:0] w_hi_sel;

    assign w_br_target = pc4 + sext18(imm18);
    assign w_j_target  = {pc4[31:28], index28};
    assign w_jr_target = rd1 & 32'hFFFF_FFFC;

    // Two-level mux tree indexed by the pcsource bits:
    // 00 seq, 01 branch, 10 jr, 11 j.
    assign w_lo_sel = mux2x32(pc4, w_br_target, pcsource[0]);
    assign w_hi_sel = mux2x32(w_jr_target, w_j_target, pcsource[0]);
    assign target   = mux2x32(w_lo_sel, w_hi_sel, pcsource[1]);

endmodule

// File: rtl/pipe_if.sv
// Instruction-fetch stage: owns the PC, issues word fetches, holds the IF/ID
// register, and parks a word returned during a stall in a one-entry skid.
module pipe_if
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [1:0]  pcsource,
    input  logic [17:0] imm18,
    input  logic [27:0] index28,
    input  logic [31:0] rd1,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        instr_valid,
    output logic [31:0] pc
);

    if_state_e   r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_instr_valid;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc4;

    if_state_e   w_state_next;
    logic [31:0] w_pc_next;
    logic [31:0] w_instr_next;
    logic [31:0] w_pc4_next;
    logic        w_instr_valid_next;
    logic [31:0] w_skid_instr_next;
    logic [31:0] w_skid_pc4_next;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

    // Redirect only counts when the instruction in IF/ID is real.
    assign w_redirect = r_instr_valid & (pcsource != PCSRC_SEQ);
    assign w_pc_plus4 = r_pc + 32'd4;

    pipe_if_npc u_npc (
        .pcsource (pcsource),
        .pc4      (r_pc4),
        .imm18    (imm18),
        .index28  (index28),
        .rd1      (rd1),
        .target   (w_target)
    );

    // Next-state and next-register decode; priority stall > redirect > word > wait.
    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_instr_next       = r_instr;
        w_pc4_next         = r_pc4;
        w_instr_valid_next = r_instr_valid;
        w_skid_instr_next  = r_skid_instr;
        w_skid_pc4_next    = r_skid_pc4;

        case (r_state)
            IF_FETCH: begin
                if (stall) begin
                    // A word arriving while ID is frozen is parked; PC stays on
                    // its address until the skid is released.
                    if (imem_valid) begin
                        w_skid_instr_next = imem_rdata;
                        w_skid_pc4_next   = w_pc_plus4;
                        w_state_next      = IF_HOLD;
                    end
                end else if (w_redirect) begin
                    // No delay slot: whatever returns this cycle is wrong-path.
                    w_pc_next          = w_target;
                    w_instr_next       = INSTR_NOP;
                    w_instr_valid_next = 1'b0;
                end else if (imem_valid) begin
                    w_instr_next       = imem_rdata;
                    w_pc4_next         = w_pc_plus4;
                    w_instr_valid_next = 1'b1;
                    w_pc_next          = w_pc_plus4;
                end else begin
                    w_instr_next       = INSTR_NOP;
                    w_instr_valid_next = 1'b0;
                end
            end
            IF_HOLD: begin
                if (!stall) begin
                    w_state_next = IF_FETCH;
                    if (w_redirect) begin
                        w_pc_next          = w_target;
                        w_instr_next       = INSTR_NOP;
                        w_instr_valid_next = 1'b0;
                    end else begin
                        w_instr_next       = r_skid_instr;
                        w_pc4_next         = r_skid_pc4;
                        w_instr_valid_next = 1'b1;
                        w_pc_next          = w_pc_plus4;
                    end
                end
            end
            default: w_state_next = IF_FETCH;
        endcase
    end

    // State, PC, IF/ID and skid registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IF_FETCH;
            r_pc          <= RESET_PC;
            r_instr       <= INSTR_NOP;
            r_pc4         <= 32'h0;
            r_instr_valid <= 1'b0;
            r_skid_instr  <= 32'h0;
            r_skid_pc4    <= 32'h0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_instr       <= w_instr_next;
            r_pc4         <= w_pc4_next;
            r_instr_valid <= w_instr_valid_next;
            r_skid_instr  <= w_skid_instr_next;
            r_skid_pc4    <= w_skid_pc4_next;
        end
    end

    assign imem_req    = (r_state == IF_FETCH);
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign pc4         = r_pc4;
    assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_pipe_if.sv
// Directed bench for pipe_if: a table of per-cycle vectors followed by a
// hand-written HOLD-redirect sequence. One line printed per transaction.
module tb_pipe_if;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [1:0]  pcsource;
    logic [17:0] imm18;
    logic [27:0] index28;
    logic [31:0] rd1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        instr_valid;
    logic [31:0] pc;

    int n_total;
    int n_pass;

    pipe_if #(.RESET_PC(32'h0000_0100)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .pcsource    (pcsource),
        .imm18       (imm18),
        .index28     (index28),
        .rd1         (rd1),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .pc4         (pc4),
        .instr_valid (instr_valid),
        .pc          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic [1:0]  pcsrc;
        logic [17:0] imm;
        logic [27:0] idx;
        logic [31:0] rd1;
        logic        mv;
        logic [31:0] mdata;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_v;
        logic        e_req;
        logic        ck_pc4;
    } vec_t;

    function automatic vec_t mk(logic r, logic s, logic [1:0] ps, logic [17:0] im,
                                logic [27:0] ix, logic [31:0] rr, logic mv,
                                logic [31:0] md, logic [31:0] epc, logic [31:0] ei,
                                logic [31:0] ep4, logic ev, logic erq, logic c4);
        vec_t t;
        t.rst = r; t.stall = s; t.pcsrc = ps; t.imm = im; t.idx = ix; t.rd1 = rr;
        t.mv = mv; t.mdata = md; t.e_pc = epc; t.e_instr = ei; t.e_pc4 = ep4;
        t.e_v = ev; t.e_req = erq; t.ck_pc4 = c4;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // Drive one cycle of inputs on the falling edge, check registered outputs 1ns after rising edge.
    task automatic step(input int id, input vec_t v);
        @(negedge clk);
        rst        = v.rst;
        stall      = v.stall;
        pcsource   = v.pcsrc;
        imm18      = v.imm;
        index28    = v.idx;
        rd1        = v.rd1;
        imem_valid = v.mv;
        imem_rdata = v.mdata;
        @(posedge clk);
        #1;
        $display("vec %0d: rst=%0b stall=%0b psrc=%0d mv=%0b -> pc=%08h instr=%08h pc4=%08h v=%0b req=%0b",
                 id, v.rst, v.stall, v.pcsrc, v.mv, pc, instr, pc4, instr_valid, imem_req);
        chk($sformatf("pc[%0d]", id), pc, v.e_pc);
        chk($sformatf("imem_addr[%0d]", id), imem_addr, v.e_pc);
        chk($sformatf("instr[%0d]", id), instr, v.e_instr);
        chk($sformatf("instr_valid[%0d]", id), {31'b0, instr_valid}, {31'b0, v.e_v});
        chk($sformatf("imem_req[%0d]", id), {31'b0, imem_req}, {31'b0, v.e_req});
        if (v.ck_pc4) chk($sformatf("pc4[%0d]", id), pc4, v.e_pc4);
    endtask

    vec_t tbl[24];
    vec_t hs[4];

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b1; stall = 1'b0; pcsource = 2'b00; imm18 = '0; index28 = '0;
        rd1 = '0; imem_valid = 1'b0; imem_rdata = '0;

        //            rst  stl psrc  imm18      index28      rd1           mv   mdata          pc             instr          pc4           v    req  ck4
        // Reset held two cycles
        tbl[0]  = mk(1'b1,1'b0,2'b00,18'h0,    28'h0,       32'h0,        1'b0,32'h0,         32'h0000_0100,32'h0,         32'h0,        1'b0,1'b1,1'b1);
        tbl[1]  = mk(1'b1,1'b0,2'b00,18'h0,    28'h0,       32'h0,        1'b1,32'h1111_1111, 32'h0000_0100,32'h0,         32'h0,        1'b0,1'b1,1'b1);
        // Sequential zero-wait fetches
        tbl[2]  = mk(1'b0,1'b0,2'b00,18'h0,    28'h0,       32'h0,        1'b1,32'h2001_0005, 32'h0000_0104,32'h2001_0005, 32'h0000_0104,1'b1,1'b1,1'b1);
        tbl[3]  = mk(1'b0,1'b0,2'b00,18'h0,    28'h0,       32'h0,        1'b1,32'h2002_0006, 32'h0000_0108,32'h2002_0006, 32'h0000_0108,1'b1,1'b1,1'b1);
        tbl[4]  = mk(1'b0,1'b0,2'b00,18'h0,    28'h0,       32'h0,        1'b1,32'h0000_0001, 32'h0000_010C,32'h0000_0001, 32'h0000_010C,1'b1,1'b1,1'b1);
        tbl[5]  = mk(1'b0,1'b0,2'b00,18'h0,    28'h0,       32'h0,        1'b1,32'h1000_FFFE, 32'h0000_0110,32'h1000_FFFE, 32'h0000_0110,1'b1,1'b1,1'b1);
        // Branch back: 0x110 + (-8) = 0x108, returned word dropped
        tbl[6]  = mk(1'b0,1'b0,2'b01,18'h3FFF8,28'h0,       32'h0,        1'b1,32'hDEAD_BEEF, 32'h0000_0108,32'h0,         32'h0,        1'b0,1'b1,1'b0);
        tbl[7]  = mk(1'b0,1'b0,2'b00,18'h0,    28'h0,       32'h0,        1'b1,32'hAAAA_0001, 32'h0000_010C,32'hAAAA_0001, 32'h0000_010C,1'b1,1'b1,1'b1);
        // jr with misaligned register -> 0x204
        tbl[8]  = mk(1'b0,1'b0,2'b10,18'h0,    28'h0,       32'h0000_0207,1'b0,32'h0,         32'h0000_0204,32'h0,         32'h0,        1'b0,1'b1,1'b0);
        tbl[9]  = mk(1'b0,1'b0,2'b00,18'h0,    28'h0,       32'h0,        1'b1,32'hBBBB_0002, 32'h0000_0208,32'hBBBB_0002, 32'h0000_0208,1'b1,1'b1,1'b1);
        // j to 0x120: {pc4[31:28]=0, index28}
        tbl[10] = mk(1'b0,1'b0,2'b11,18'h0,    28'h000_0120,32'h0,        1'b0,32'h0,         32'h0000_0120,32'h0,         32'h0,        1'b0,1'b1,1'b0);
        // Stall 3 cycles while the word for 0x120 returns
        tbl[11] = mk(1'b0,1'b1,2'b00,18'h0,    28'h0,       32'h0,        1'b1,32'hCCCC_0003, 32'h0000_0120,32'h0,         32'h0,        1'b0,1'b0,1'b0);
        tbl[12] = mk(1'b0,1'b1,2'b00,18'h0,    28'h0,       32'h0,        1'b1,32'hEEEE_0000, 32'h0000_0120,32'h0,         32'h0,        1'b0,1'b0,1'b0);
        tbl[13] = mk(1'b0,1'b1,2'b00,18'h0,    28'h0,       32'h0,        1'b0,32'h0,         32'h0000_0120,32'h0,         32'h0,        1'b0,1'b0,1'b0);
        // Release: skid word enters IF/ID, memory response ignored
        tbl[14] = mk(1'b0,1'b0,2'b00,18'h0,    28'h0,       32'h0,        1'b1,32'hFFFF_0000, 32'h0000_0124,32'hCCCC_0003, 32'h0000_0124,1'b1,1'b1,1'b1);
        // Two wait states -> bubbles, pc held
        tbl[15] = mk(1'b0,1'b0,2'b00,18'h0,    28'h0,       32'h0,        1'b0,32'h0,         32'h0000_0124,32'h0,         32'h0,        1'b0,1'b1,1'b0);
        tbl[16] = mk(1'b0,1'b0,2'b00,18'h0,    28'h0,       32'h0,        1'b0,32'h0,         32'h0000_0124,32'h0,         32'h0,        1'b0,1'b1,1'b0);
        // Into HOLD, then reset while in HOLD
        tbl[17] = mk(1'b0,1'b1,2'b00,18'h0,    28'h0,       32'h0,        1'b1,32'h1234_5678, 32'h0000_0124,32'h0,         32'h0,        1'b0,1'b0,1'b0);
        tbl[18] = mk(1'b1,1'b1,2'b00,18'h0,    28'h0,       32'h0,        1'b0,32'h0,         32'h0000_0100,32'h0,         32'h0,        1'b0,1'b1,1'b1);
        // After reset the skid content must not reappear
        tbl[19] = mk(1'b0,1'b0,2'b00,18'h0,    28'h0,       32'h0,        1'b1,32'h5555_0000, 32'h0000_0104,32'h5555_0000, 32'h0000_0104,1'b1,1'b1,1'b1);
        // jr to top of address space, then PC+4 wraps to 0
        tbl[20] = mk(1'b0,1'b0,2'b10,18'h0,    28'h0,       32'hFFFF_FFFF,1'b0,32'h0,         32'hFFFF_FFFC,32'h0,         32'h0,        1'b0,1'b1,1'b0);
        tbl[21] = mk(1'b0,1'b0,2'b00,18'h0,    28'h0,       32'h0,        1'b1,32'h7777_0007, 32'h0000_0000,32'h7777_0007, 32'h0000_0000,1'b1,1'b1,1'b1);
        // Stall beats redirect: IF/ID and pc frozen
        tbl[22] = mk(1'b0,1'b1,2'b01,18'h00100,28'h0,       32'h0,        1'b0,32'h0,         32'h0000_0000,32'h7777_0007, 32'h0000_0000,1'b1,1'b1,1'b1);
        // Forward branch from pc4=0: target 0x100
        tbl[23] = mk(1'b0,1'b0,2'b01,18'h00100,28'h0,       32'h0,        1'b0,32'h0,         32'h0000_0100,32'h0,         32'h0,        1'b0,1'b1,1'b0);

        for (int i = 0; i < 24; i++) step(i, tbl[i]);

        // Hand-written: redirect taken out of HOLD discards the skid.
        hs[0] = mk(1'b0,1'b0,2'b00,18'h0,28'h0,       32'h0,1'b1,32'h9999_0001,32'h0000_0104,32'h9999_0001,32'h0000_0104,1'b1,1'b1,1'b1);
        hs[1] = mk(1'b0,1'b1,2'b00,18'h0,28'h0,       32'h0,1'b1,32'h8888_0002,32'h0000_0104,32'h9999_0001,32'h0000_0104,1'b1,1'b0,1'b1);
        hs[2] = mk(1'b0,1'b0,2'b11,18'h0,28'h000_0040,32'h0,1'b1,32'h3333_0000,32'h0000_0040,32'h0,        32'h0,        1'b0,1'b1,1'b0);
        hs[3] = mk(1'b0,1'b0,2'b00,18'h0,28'h0,       32'h0,1'b1,32'h4444_0004,32'h0000_0044,32'h4444_0004,32'h0000_0044,1'b1,1'b1,1'b1);
        for (int i = 0; i < 4; i++) step(100 + i, hs[i]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_if.md
# pipe_if

Instruction-fetch stage of the five-stage CPU, directly upstream of `pipe_id`. It owns the program counter, issues word fetches to instruction memory, and holds the IF/ID pipeline register (`instr`, `pc4`). It also computes the next PC from the redirect information decoded in ID: `pcsource`, `imm18`, `index28` and `rd1`. A one-entry skid register keeps a fetched word that returns while the pipeline is stalled.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; word-aligned.

Ports:
- `clk`  in  1  pipeline clock.
- `rst`  in  1  reset; synchronous, active-high.
- `stall`  in  1  hazard stall from ID; freezes the PC and IF/ID register.
- `pcsource`  in  2  redirect select from the control unit for the instruction now in IF/ID: 00 sequential, 01 branch, 10 jr, 11 j/jal.
- `imm18`  in  18  branch offset (imm<<2), sign bit [17].
- `index28`  in  28  jump index (index<<2).
- `rd1`  in  32  register operand used as the jr target.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address, equal to `pc`.
- `imem_valid`  in  1  `imem_rdata` is valid this cycle for `imem_addr`; low means a wait state.
- `imem_rdata`  in  32  fetched word.
- `instr`  out  32  IF/ID instruction, fed to `pipe_id.instr`.
- `pc4`  out  32  IF/ID PC+4 of `instr`.
- `instr_valid`  out  1  `instr` is a real instruction, not a bubble.
- `pc`  out  32  current fetch PC.

## Operation
- Reset values: `pc`=RESET_PC, `instr`=32'h0 (NOP), `pc4`=32'h0, `instr_valid`=0, skid empty, state FETCH.
- States:
  - FETCH: `imem_req`=1.
  - HOLD: the skid is full, `imem_req`=0.
- `redirect` = `instr_valid` & (`pcsource`!=00).
- Targets:
  - Branch: `pc4` + sext32(`imm18`).
  - j: {`pc4`[31:28], `index28`}.
  - jr: {`rd1`[31:2], 2'b00}. Low bits are forced to zero.
  - All additions are modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- Per-cycle priority: `rst` > `stall` > `redirect` > word-available > wait.
- FETCH state, by case:
  - `stall`=1 and `imem_valid`=1: the word goes to the skid with `pc`+4, and the state moves to HOLD. PC and IF/ID hold.
  - `stall`=1 and `imem_valid`=0: everything holds.
  - `redirect` (`stall`=0): `pc`<=target. IF/ID <= NOP with `instr_valid`=0. Any word returning this cycle is discarded as wrong-path. There is no delay slot.
  - `imem_valid`=1 (`stall`=0, no redirect): IF/ID <= {`imem_rdata`, `pc`+4}, `instr_valid`=1, and `pc`<=`pc`+4.
  - `imem_valid`=0 (`stall`=0, no redirect): IF/ID <= bubble, and `pc` holds.
- HOLD state, by case:
  - `stall`=1: everything holds, and `imem_req` stays 0.
  - `stall`=0 and `redirect`: the skid is discarded, `pc`<=target, IF/ID <= bubble, and the state returns to FETCH.
  - `stall`=0 and no redirect: IF/ID <= skid contents with `instr_valid`=1, `pc`<=`pc`+4, and the state returns to FETCH.
- When `imem_req`=0, `imem_valid` is ignored.
- `rst` asserted in any state overrides everything on the next edge, including in HOLD.

## Timing
- Fetch-to-ID latency: 1 cycle with zero wait states. The word returned at edge N appears on `instr` after edge N.
- Zero-wait sequential throughput: 1 instruction per cycle.
- Redirect penalty: 1 bubble. The target word is in IF/ID two edges after the branch entered IF/ID.
- Skid release: 1 cycle after `stall` falls, with no new memory access that cycle.
- Outputs are registered, except `imem_req` (decoded from state) and `imem_addr`=`pc`.

## Structure
- Shared package `cpu_defs`, containing:
  - `PCSRC_SEQ`=2'b00, `PCSRC_BR`=2'b01, `PCSRC_JR`=2'b10, `PCSRC_J`=2'b11.
  - `INSTR_NOP`=32'h0.
  - The IF state encoding: FETCH=1'b0, HOLD=1'b1.
- Sub-module `pipe_if_npc`: combinational target selection from `pcsource`, `pc4`, `imm18`, `index28`, `rd1`. It reuses `mux2x32`-style selection and the sign-extension rule of `ext`.

## Test plan
- Reset: hold `rst` 2 cycles, RESET_PC=32'h100 -> `pc`=32'h100, `instr`=0, `instr_valid`=0, `imem_req`=1 on the first cycle after reset.
- Sequential, zero wait: memory returns 32'h2001_0005, then 32'h2002_0006 -> `instr` shows each one cycle later, `pc4`=32'h104 then 32'h108, `pc` steps by 4.
- Branch back: branch in IF/ID with `pc4`=32'h110, `pcsource`=01, `imm18`=18'h3FFF8 -> next `pc`=32'h108, next `instr_valid`=0, and the word returned that cycle is dropped.
- jr misaligned: `pcsource`=10, `rd1`=32'h0000_0207 -> `pc`=32'h0000_0204.
- Stall with return: `stall`=1 for 3 cycles while the word for 32'h120 returns -> state HOLD, `imem_req`=0 for 2 cycles, `instr` unchanged. On release, `instr` = that word with `pc4`=32'h124, and `pc`=32'h124.
- Wait states and mid-HOLD reset: `imem_valid`=0 for 2 cycles -> 2 bubbles with `pc` held. Then `rst` asserted in HOLD -> skid cleared, `pc`=RESET_PC, state FETCH.
